// File: rtl/mem_access_sequencer_if.sv
// Bundle of the core request/response port and the memory bus port of the load/store sequencer.
// A bus beat completes on the rising clock edge where mem_valid & mem_ready; mem_* request signals hold until then.
interface mem_access_sequencer_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;
  logic            rsp_misaligned;
  logic [XLEN-1:0] rsp_badaddr;

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_fault;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  mem_ready, mem_fault, mem_rdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_fault, rsp_misaligned, rsp_badaddr,
    output mem_valid, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output mem_ready, mem_fault, mem_rdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_fault, rsp_misaligned, rsp_badaddr,
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Load/store bus sequencer: one request at a time, word-crossing accesses split into two aligned beats,
// with misalignment, bus fault and per-beat timeout reporting.
module mem_access_sequencer #(
  parameter int XLEN               = 32,
  parameter bit SUPPORT_MISALIGNED = 1'b1,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_access_sequencer_if.master bus,
  output logic [1:0]            state_dbg
);
  localparam int NB     = XLEN / 8;
  localparam int NB2    = 2 * NB;
  localparam int LOG_NB = $clog2(NB);
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nx;

  logic [LOG_NB-1:0] req_off, a_off;
  logic [4:0]        req_len;
  logic              req_cross, req_mis, reject;
  logic [NB2-1:0]    strb_full;
  logic [2*XLEN-1:0] wd_full, rd_full;

  logic [XLEN-1:0]   a_addr, rdata0, b1_wdata;
  logic [1:0]        a_size;
  logic              a_cross, a_we, a_signed;
  logic [NB-1:0]     b1_wstrb;
  logic [31:0]       tcnt;

  logic              mem_valid_q;
  logic [XLEN-1:0]   mem_addr_q, mem_wdata_q;
  logic [NB-1:0]     mem_wstrb_q;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_badaddr_q;
  logic              rsp_fault_q, rsp_mis_q;

  logic              beat_done, timeout, sbit;
  logic [XLEN-1:0]   shifted, keep, load_data;

  // Alignment terms of the incoming request
  assign req_off   = bus.req_addr[LOG_NB-1:0];
  assign req_len   = 5'd1 << bus.req_size;
  assign req_cross = (5'(req_off) + req_len) > 5'(NB);
  assign req_mis   = (5'(req_off) & (req_len - 5'd1)) != 5'd0;
  assign reject    = !SUPPORT_MISALIGNED && req_mis;

  // Low half of each double-width vector belongs to beat0, high half to beat1
  assign strb_full = NB2'((17'd1 << req_len) - 17'd1) << req_off;
  assign wd_full   = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};

  assign beat_done = mem_valid_q && bus.mem_ready;
  assign timeout   = (TIMEOUT_CYCLES != 0) && mem_valid_q && !bus.mem_ready && (tcnt == TO_LAST);

  assign rd_full = (state == BEAT1) ? {bus.mem_rdata, rdata0} : {{XLEN{1'b0}}, bus.mem_rdata};

  always_comb begin
    shifted = XLEN'(rd_full >> {a_off, 3'b000});
    keep    = '1;
    sbit    = shifted[XLEN-1];
    case (a_size)
      2'd0: begin keep = XLEN'(8'hFF);          sbit = shifted[7];  end
      2'd1: begin keep = XLEN'(16'hFFFF);       sbit = shifted[15]; end
      2'd2: begin keep = XLEN'(32'hFFFF_FFFF);  sbit = shifted[31]; end
      default: ;
    endcase
    load_data = (shifted & keep) | (~keep & {XLEN{a_signed & sbit}});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.req_valid) state_nx = reject ? RESP : BEAT0;
      BEAT0: begin
        if (beat_done)    state_nx = (a_cross && !bus.mem_fault) ? BEAT1 : RESP;
        else if (timeout) state_nx = RESP;
      end
      BEAT1: if (beat_done || timeout) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_addr        <= '0;
      a_off         <= '0;
      a_size        <= '0;
      a_cross       <= 1'b0;
      a_we          <= 1'b0;
      a_signed      <= 1'b0;
      rdata0        <= '0;
      b1_wstrb      <= '0;
      b1_wdata      <= '0;
      tcnt          <= '0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_badaddr_q <= '0;
      rsp_fault_q   <= 1'b0;
      rsp_mis_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          a_addr        <= bus.req_addr;
          a_off         <= req_off;
          a_size        <= bus.req_size;
          a_cross       <= req_cross;
          a_we          <= bus.req_we;
          a_signed      <= bus.req_signed;
          tcnt          <= '0;
          rsp_rdata_q   <= '0;
          rsp_badaddr_q <= '0;
          rsp_fault_q   <= 1'b0;
          rsp_mis_q     <= 1'b0;
          if (reject) begin
            rsp_mis_q     <= 1'b1;
            rsp_badaddr_q <= bus.req_addr;
          end else begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {bus.req_addr[XLEN-1:LOG_NB], {LOG_NB{1'b0}}};
            mem_wstrb_q <= bus.req_we ? strb_full[NB-1:0] : '0;
            mem_wdata_q <= bus.req_we ? wd_full[XLEN-1:0] : '0;
            b1_wstrb    <= bus.req_we ? strb_full[NB2-1:NB] : '0;
            b1_wdata    <= bus.req_we ? wd_full[2*XLEN-1:XLEN] : '0;
          end
        end
        BEAT0: begin
          if (beat_done) begin
            mem_valid_q <= 1'b0;
            tcnt        <= '0;
            if (bus.mem_fault) begin
              rsp_fault_q   <= 1'b1;
              rsp_badaddr_q <= a_addr;
            end else if (a_cross) begin
              rdata0      <= bus.mem_rdata;
              mem_addr_q  <= mem_addr_q + XLEN'(NB);
              mem_wstrb_q <= b1_wstrb;
              mem_wdata_q <= b1_wdata;
            end else if (!a_we) begin
              rsp_rdata_q <= load_data;
            end
          end else if (timeout) begin
            mem_valid_q   <= 1'b0;
            rsp_fault_q   <= 1'b1;
            rsp_badaddr_q <= a_addr;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        BEAT1: begin
          // One idle bus cycle separates the beats; valid re-asserts here
          if (!mem_valid_q) begin
            mem_valid_q <= 1'b1;
          end else if (beat_done) begin
            mem_valid_q <= 1'b0;
            if (bus.mem_fault) begin
              rsp_fault_q   <= 1'b1;
              rsp_badaddr_q <= mem_addr_q;
            end else if (!a_we) begin
              rsp_rdata_q <= load_data;
            end
          end else if (timeout) begin
            mem_valid_q   <= 1'b0;
            rsp_fault_q   <= 1'b1;
            rsp_badaddr_q <= mem_addr_q;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.rsp_valid      = (state == RESP);
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_fault      = rsp_fault_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_badaddr    = rsp_badaddr_q;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wstrb      = mem_wstrb_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign state_dbg          = state;
endmodule
